word_clip_ctrl: RTL
===================

Name: word_clip_ctrl

Overview:
- Sequencer that scans a captured audio buffer through the word clipper datapath and hands the first acceptable word segment to the feature-extraction stage.
- On a start pulse it reads samples from the sample buffer over a 1-cycle-latency read port, converts them to magnitudes, and streams them with index and last flags into the clipper.
- It holds the clipper in reset between scans, filters out segments shorter than MIN_LEN, and reports the segment over a valid/ready handshake.
- It sits between the capture buffer, the word clipper and the feature-extraction front end.

Parameters:
- ADDR_W, 16, sample buffer address width; ilen width.
- MIN_LEN, 800, minimum accepted word length in samples; shorter clips are discarded and the scan continues.

Ports:
- iclk  in  1  clock.
- irstn  in  1  reset; asynchronous, active-low.
- istart  in  1  single-cycle scan request; ignored while obusy=1.
- ilen  in  ADDR_W  number of valid buffer samples; sampled when istart is accepted.
- ordaddr  out  ADDR_W  buffer read address.
- oren  out  1  buffer read enable; ordata is valid the cycle after oren=1.
- ordata  in  16  signed buffer sample.
- oclip_rstn  out  1  synchronous active-low reset to the clipper.
- oclip_valid  out  1  sample-present strobe to the clipper.
- oclip_last  out  1  last-sample flag to the clipper.
- oclip_idx  out  32  sample index, zero-extended address.
- oclip_data  out  16  sample magnitude.
- iclip_valid  in  1  clipper segment-found strobe, 1 cycle.
- iclip_start  in  32  clipper start index.
- iclip_end  in  32  clipper end index.
- oseg_valid  out  1  segment available.
- iseg_ready  in  1  downstream accepts the segment.
- oseg_start  out  32  accepted start index.
- oseg_len  out  32  accepted length.
- obusy  out  1  scan in progress.
- odone  out  1  1-cycle pulse at scan end.
- onoword  out  1  qualifies odone: no acceptable word found; held until the next istart.

Behaviour:
- Reset: every output is 0, including oclip_rstn (clipper held in reset). The state is IDLE. An asynchronous reset mid-scan aborts the scan and emits no odone.
- IDLE:
  - oclip_rstn=0 and obusy=0.
  - istart=1 with ilen=0: go to DONE with onoword=1.
  - istart=1 otherwise: latch ilen, set addr=0, go to PRIME.
- PRIME (1 cycle):
  - oren=1, ordaddr=0, oclip_rstn=1.
  - Go to STREAM.
- STREAM:
  - Each cycle, while addr<len: oren=1, ordaddr=addr, then addr increments.
  - Feed cycle k is the cycle after the read of address k.
  - Feed cycle k drives: oclip_valid=1; oclip_idx=k; oclip_data=|ordata|, with -32768 saturated to 16'h7FFF; oclip_last=(k==len-1).
  - Feeds are contiguous; sample 0 is fed 2 cycles after istart.
- iclip_valid=1 during STREAM or DRAIN:
  - Compute L = iclip_end - iclip_start + 1, 32-bit unsigned.
  - If L >= MIN_LEN: register oseg_start=iclip_start and oseg_len=L, stop reads immediately, drive oclip_rstn=0, go to OFFER.
  - Otherwise discard the segment. The clipper self-returns to idle, and streaming continues uninterrupted.
- DRAIN (1 cycle after the feed of k=len-1):
  - No feed.
  - If iclip_valid=1: handle it as above. Otherwise go to DONE with onoword=1.
  - A rejected segment in DRAIN also goes to DONE with onoword=1.
- OFFER:
  - oseg_valid=1, with oseg_start and oseg_len stable.
  - Leave when iseg_ready=1 in the same cycle; go to DONE with onoword=0.
- DONE (1 cycle): odone=1, then go to IDLE.
- obusy=1 in every state except IDLE.
- istart during obusy is dropped; there is no queueing.

Test Plan:
- Word accepted: len=4000, |samples|=0x0010 except 0x0050 at indices 1000..1099, 0x0400 at 1100..2099, 0x0050 at 2100..2199 -> oseg_start=1000, oseg_len=1200; odone=1 and onoword=0 after the handshake; oclip_rstn=0 during OFFER.
- Silence: len=2000, all samples 0x0005 -> after the last feed plus DRAIN, odone=1 and onoword=1; oseg_valid is never asserted.
- Short word rejected, then accepted: a 300-sample burst at index 100, then a 1500-sample burst at index 1000 -> the first is discarded without a stall; the second gives oseg_start=1000 and oseg_len=1500.
- Word running to end of buffer: len=3000, loud from index 2000 to 2999 -> the clipper ends via oclip_last; oseg_len=1000, accepted in DRAIN.
- Backpressure: iseg_ready=0 for 5 cycles in OFFER -> oseg_valid and its data are held stable; odone appears on the cycle after ready.
- Edge cases:
  - ilen=0 -> odone and onoword the cycle after istart; no reads.
  - Sample 0x8000 -> oclip_data=0x7FFF.
  - Sample 0xFF00 -> oclip_data=0x0100.
  - irstn low mid-STREAM -> all outputs 0 immediately.

Source files
------------

// File: rtl/word_clip_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// word_clip_ctrl_if : scan request, buffer read, clipper and segment buses
// Rev 1.0
// ------------------------------------------------------------------
interface word_clip_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              istart;
    logic [ADDR_W-1:0] ilen;
    logic [ADDR_W-1:0] ordaddr;
    logic              oren;
    logic [15:0]       ordata;
    logic              oclip_rstn;
    logic              oclip_valid;
    logic              oclip_last;
    logic [31:0]       oclip_idx;
    logic [15:0]       oclip_data;
    logic              iclip_valid;
    logic [31:0]       iclip_start;
    logic [31:0]       iclip_end;
    logic              oseg_valid;
    logic              iseg_ready;
    logic [31:0]       oseg_start;
    logic [31:0]       oseg_len;
    logic              obusy;
    logic              odone;
    logic              onoword;

    modport master (
        input  istart, ilen, ordata, iclip_valid, iclip_start, iclip_end, iseg_ready,
        output ordaddr, oren, oclip_rstn, oclip_valid, oclip_last, oclip_idx, oclip_data,
               oseg_valid, oseg_start, oseg_len, obusy, odone, onoword
    );

    modport slave (
        output istart, ilen, ordata, iclip_valid, iclip_start, iclip_end, iseg_ready,
        input  ordaddr, oren, oclip_rstn, oclip_valid, oclip_last, oclip_idx, oclip_data,
               oseg_valid, oseg_start, oseg_len, obusy, odone, onoword
    );
endinterface
`default_nettype wire

// File: rtl/word_clip_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// word_clip_ctrl : streams buffer magnitudes into the word clipper and
//                  offers the first segment of at least MIN_LEN samples
// Rev 1.0
// ------------------------------------------------------------------
module word_clip_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int MIN_LEN = 800
) (
    input wire               iclk,
    input wire               irstn,
    word_clip_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_OFFER  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] C_ONE     = ADDR_W'(1);
    localparam logic [31:0]       C_MIN_LEN = 32'(MIN_LEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_rd_pend;
    logic [31:0]       r_seg_start;
    logic [31:0]       r_seg_len;
    logic              r_noword;

    logic [31:0]       w_clip_len;
    logic              w_clip_hit;
    logic              w_accept;
    logic              w_feed;
    logic              w_feed_last;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_clip_rstn;
    logic [15:0]       w_mag;

    assign w_clip_len  = bus.iclip_end - bus.iclip_start + 32'd1;
    assign w_clip_hit  = bus.iclip_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN));
    assign w_accept    = w_clip_hit && (w_clip_len >= C_MIN_LEN);
    // A feed is the data returned for the read issued on the previous cycle
    assign w_feed      = r_rd_pend && (r_state == S_STREAM);
    assign w_feed_last = w_feed && (r_rd_idx == (r_len - C_ONE));

    always_comb begin
        if (bus.ordata == 16'h8000) begin
            w_mag = 16'h7FFF;
        end else if (bus.ordata[15]) begin
            w_mag = 16'h0000 - bus.ordata;
        end else begin
            w_mag = bus.ordata;
        end
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_clip_rstn = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.istart) begin
                    w_state_nxt = (bus.ilen == '0) ? S_DONE : S_PRIME;
                end
            end
            S_PRIME: begin
                w_rd_en     = 1'b1;
                w_clip_rstn = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                w_clip_rstn = !w_accept;
                if (w_accept) begin
                    w_state_nxt = S_OFFER;
                end else begin
                    if (r_addr < r_len) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = r_addr;
                    end
                    if (w_feed_last) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_clip_rstn = !w_accept;
                w_state_nxt = w_accept ? S_OFFER : S_DONE;
            end
            S_OFFER: begin
                if (bus.iseg_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            r_len       <= '0;
            r_addr      <= '0;
            r_rd_idx    <= '0;
            r_rd_pend   <= 1'b0;
            r_seg_start <= '0;
            r_seg_len   <= '0;
            r_noword    <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            r_rd_idx  <= w_rd_addr;
            if (w_rd_en) begin
                r_addr <= w_rd_addr + C_ONE;
            end
            if ((r_state == S_IDLE) && bus.istart) begin
                r_len    <= bus.ilen;
                r_addr   <= '0;
                r_noword <= (bus.ilen == '0);
            end
            if ((r_state == S_DRAIN) && !w_accept) begin
                r_noword <= 1'b1;
            end
            if (w_accept) begin
                r_seg_start <= bus.iclip_start;
                r_seg_len   <= w_clip_len;
            end
        end
    end

    assign bus.ordaddr     = w_rd_addr;
    assign bus.oren        = w_rd_en;
    assign bus.oclip_rstn  = w_clip_rstn;
    assign bus.oclip_valid = w_feed;
    assign bus.oclip_last  = w_feed_last;
    assign bus.oclip_idx   = w_feed ? 32'(r_rd_idx) : 32'd0;
    assign bus.oclip_data  = w_feed ? w_mag : 16'd0;
    assign bus.oseg_valid  = (r_state == S_OFFER);
    assign bus.oseg_start  = r_seg_start;
    assign bus.oseg_len    = r_seg_len;
    assign bus.obusy       = (r_state != S_IDLE);
    assign bus.odone       = (r_state == S_DONE);
    assign bus.onoword     = r_noword;
endmodule
`default_nettype wire
